// File: rtl/cache_top.sv
// Direct-mapped byte-addressed data cache: 8 lines x 32 bytes.
// A miss refills the whole line one byte per cycle from a byte-wide memory
// port and then completes the access as a hit. A 5-to-32 decoder produces
// the per-byte write enables for both CPU writes and refill writes.

module decoder5to32 (
    input  logic [4:0]  in,
    output logic [31:0] out
);

    // One-hot decode of the 5-bit select
    always_comb begin
        out = 32'd1 << in;
    end

endmodule

module cache_top (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pcOut,
    input  logic         memWrite,
    input  logic [7:0]   MemOut,
    input  logic [7:0]   dataIn,
    output logic [7:0]   dataOut,
    output logic [255:0] blockOut
);

    typedef enum logic [0:0] {
        ST_LOOKUP = 1'b0,
        ST_FILL   = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    cnt_q;
    logic [2:0]    fill_idx_q;
    logic [23:0]   fill_tag_q;
    logic [7:0]    dout_q;

    logic [255:0]  data_q  [8];
    logic [23:0]   tag_q   [8];
    logic [7:0]    valid_q;

    logic [2:0]    idx_s;
    logic [4:0]    off_s;
    logic [23:0]   tag_in_s;
    logic          hit_s;

    logic          hit_wr_s;
    logic          rd_en_s;
    logic          miss_s;
    logic          fill_we_s;
    logic          fill_last_s;
    logic          line_we_s;
    logic [2:0]    wr_idx_s;
    logic [7:0]    wr_byte_s;
    logic [4:0]    dec_sel_s;
    logic [31:0]   byte_en_s;

    assign idx_s    = pcOut[7:5];
    assign off_s    = pcOut[4:0];
    assign tag_in_s = pcOut[31:8];
    assign hit_s    = valid_q[idx_s] & (tag_q[idx_s] == tag_in_s);
    assign line_we_s = hit_wr_s | fill_we_s;

    // Byte enables: offset drives the decoder on a CPU write, counter during refill
    decoder5to32 u_dec (
        .in  (dec_sel_s),
        .out (byte_en_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOOKUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: miss enters FILL, 32nd refill byte returns to LOOKUP
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOOKUP: begin
                if (!hit_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_FILL: begin
                if (cnt_q == 5'd31) begin
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_LOOKUP;
        endcase
    end

    // Output/control decode per state, including write-port muxing
    always_comb begin
        hit_wr_s    = 1'b0;
        rd_en_s     = 1'b0;
        miss_s      = 1'b0;
        fill_we_s   = 1'b0;
        fill_last_s = 1'b0;
        wr_idx_s    = idx_s;
        wr_byte_s   = dataIn;
        dec_sel_s   = off_s;
        case (state_q)
            ST_LOOKUP: begin
                if (hit_s) begin
                    if (memWrite) begin
                        hit_wr_s = 1'b1;
                    end else begin
                        rd_en_s = 1'b1;
                    end
                end else begin
                    miss_s = 1'b1;
                end
            end
            ST_FILL: begin
                fill_we_s = 1'b1;
                wr_idx_s  = fill_idx_q;
                wr_byte_s = MemOut;
                dec_sel_s = cnt_q;
                if (cnt_q == 5'd31) begin
                    fill_last_s = 1'b1;
                end else begin
                    fill_last_s = 1'b0;
                end
            end
            default: begin
                hit_wr_s = 1'b0;
            end
        endcase
    end

    // Refill bookkeeping: latch index/tag on a miss, count bytes during FILL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= 5'd0;
            fill_idx_q <= 3'd0;
            fill_tag_q <= 24'd0;
        end else if (miss_s) begin
            cnt_q      <= 5'd0;
            fill_idx_q <= idx_s;
            fill_tag_q <= tag_in_s;
        end else if (fill_we_s) begin
            cnt_q <= cnt_q + 5'd1;
        end
    end

    // Line data array: one byte written per enabled cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= 256'd0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                for (int k = 0; k < 32; k++) begin
                    if (line_we_s && (wr_idx_s == 3'(i)) && byte_en_s[k]) begin
                        data_q[i][8*k +: 8] <= wr_byte_s;
                    end
                end
            end
        end
    end

    // Valid/tag: the line becomes valid only with its last refill byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i] <= 24'd0;
            end
        end else if (fill_last_s) begin
            valid_q[fill_idx_q] <= 1'b1;
            tag_q[fill_idx_q]   <= fill_tag_q;
        end
    end

    // Registered read data, updated only by a hit read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= 8'h00;
        end else if (rd_en_s) begin
            dout_q <= data_q[idx_s][{off_s, 3'b000} +: 8];
        end
    end

    assign dataOut  = dout_q;
    assign blockOut = data_q[idx_s];

endmodule

// File: tb/tb_cache_top.sv
// Bench for cache_top: directed steps plus randomized accesses checked
// against a line/byte-array reference model of the cache.

module tb_cache_top;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pcOut;
    logic         memWrite;
    logic [7:0]   MemOut;
    logic [7:0]   dataIn;
    logic [7:0]   dataOut;
    logic [255:0] blockOut;
    logic [4:0]   dec_in;
    logic [31:0]  dec_out;

    int errors = 0;
    int checks = 0;

    bit         m_valid [8];
    logic [23:0] m_tag  [8];
    logic [7:0]  m_data [8][32];
    logic [7:0]  m_dout;

    always #5 clk = ~clk;

    cache_top dut (
        .clk      (clk),
        .reset    (reset),
        .pcOut    (pcOut),
        .memWrite (memWrite),
        .MemOut   (MemOut),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .blockOut (blockOut)
    );

    decoder5to32 u_dec_tb (
        .in  (dec_in),
        .out (dec_out)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] m_line(input int idx);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = m_data[idx][k];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 24'd0;
            for (int k = 0; k < 32; k++) m_data[i][k] = 8'h00;
        end
        m_dout = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 random refill bytes, 1 byte = counter, 2 constant 0x03
    task automatic do_access(input logic [31:0] addr, input bit wr, input logic [7:0] din,
                             input int mode, input bit scramble);
        int idx;
        int off;
        logic [7:0] fill [32];
        idx = int'(addr[7:5]);
        off = int'(addr[4:0]);
        pcOut = addr; memWrite = wr; dataIn = din;
        if (!(m_valid[idx] && m_tag[idx] == addr[31:8])) begin
            step();
            check("miss_detect_dout", dataOut, m_dout);
            for (int c = 0; c < 32; c++) begin
                if (mode == 1)      MemOut = 8'(c);
                else if (mode == 2) MemOut = 8'h03;
                else                MemOut = 8'($urandom);
                fill[c] = MemOut;
                if (scramble) begin
                    pcOut = $urandom; memWrite = 1'($urandom); dataIn = 8'($urandom);
                end
                step();
            end
            pcOut = addr; memWrite = wr; dataIn = din;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = addr[31:8];
            for (int k = 0; k < 32; k++) m_data[idx][k] = fill[k];
            check("fill_block", blockOut, m_line(idx));
            check("fill_dout_hold", dataOut, m_dout);
        end
        step();
        if (wr) m_data[idx][off] = din;
        else    m_dout = m_data[idx][off];
        check("access_dout", dataOut, m_dout);
        check("access_block", blockOut, m_line(idx));
    endtask

    initial begin
        logic [31:0] a;
        model_reset();
        reset = 1'b0; pcOut = 32'h62; memWrite = 1'b0; MemOut = 8'h00; dataIn = 8'h00; dec_in = 5'd0;
        #12;
        check("reset_dout", dataOut, 8'h00);
        check("reset_block", blockOut, 256'd0);
        reset = 1'b1;

        // First miss: refill with 0x03
        do_access(32'h62, 1'b0, 8'h00, 2, 1'b0);
        check("fill03_dout", dataOut, 8'h03);
        // Hit write
        do_access(32'h62, 1'b1, 8'hA5, 0, 1'b0);
        // Read the whole line back
        for (int i = 32'h60; i <= 32'h7F; i++) do_access(32'(i), 1'b0, 8'h00, 0, 1'b0);
        // Conflict miss, then original address misses again
        do_access(32'h162, 1'b0, 8'h00, 1, 1'b1);
        check("conflict_byte2", dataOut, 8'h02);
        do_access(32'h62, 1'b0, 8'h00, 0, 1'b0);

        // Randomized accesses over a small tag/index set
        for (int n = 0; n < 60; n++) begin
            a = {22'd0, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 5'($urandom)};
            do_access(a, 1'($urandom), 8'($urandom), 0, 1'b1);
        end

        // Reset in the middle of a refill
        pcOut = 32'h345; memWrite = 1'b0;
        step();
        for (int c = 0; c < 10; c++) begin
            MemOut = 8'($urandom);
            step();
        end
        reset = 1'b0;
        #2;
        check("midfill_reset_dout", dataOut, 8'h00);
        check("midfill_reset_block", blockOut, 256'd0);
        model_reset();
        reset = 1'b1;
        do_access(32'h345, 1'b0, 8'h00, 0, 1'b0);
        do_access(32'h344, 1'b0, 8'h00, 0, 1'b0);

        // Decoder sweep
        for (int i = 0; i < 32; i++) begin
            dec_in = 5'(i);
            #1;
            check("dec_onehot", dec_out, 32'd1 << i);
            check("dec_popcount", 256'($countones(dec_out)), 256'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
